serial_frame_tx: RTL
====================

Name: serial_frame_tx

Overview:
Serial frame transmitter; the send-side counterpart of the team's pattern-detect/count receiver controller.
- On a start handshake it captures a parallel data word.
- It then shifts out a fixed preamble followed by the data word, MSB first, one bit per clock.
- After the frame it holds a fixed idle gap, then returns to ready.
- Sits between a host that supplies bytes and the single-wire serial link feeding the receiver.

Parameters:
PRE_W, 4, preamble width in bits (>=1).
PREAMBLE, 4'b1101, preamble pattern, sent MSB first; must match the receiver's detect pattern.
DATA_W, 8, payload width in bits (>=1).
GAP, 2, idle cycles after the last payload bit before returning to Idle (>=1).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request; level-sensitive, held-then-released handshake.
data_in  input  DATA_W  payload word; sampled while in Init.
ser_out  output  1  serial bit; 0 whenever ser_valid=0.
ser_valid  output  1  high on every cycle ser_out carries a frame bit.
in_data  output  1  high while payload bits (not preamble) are on ser_out.
ready  output  1  high in Idle only.
done  output  1  one-cycle pulse on the final Gap cycle.

Behaviour:
- State register ps; next-state logic is combinational. Registers: ps (3b), shift register sreg (PRE_W+DATA_W), bit counter cnt (wide enough for max(PRE_W, DATA_W, GAP)).
- Reset (rst=0, async): ps=Idle, sreg=0, cnt=0. All outputs take their Idle values immediately: ready=1; ser_out, ser_valid, in_data, done = 0.
- Idle: ready=1. If start=1, go to Init; else stay.
- Init:
  - Each cycle, sreg <= {PREAMBLE, data_in} and cnt <= 0.
  - Stay while start=1.
  - When start=0, go to Pre. The data_in value present on the last Init cycle (start=0) is the one transmitted.
- Pre:
  - ser_valid=1, ser_out=sreg MSB, in_data=0.
  - Each cycle sreg shifts left by 1 with 0 filled in, and cnt increments.
  - When cnt==PRE_W-1: cnt <= 0, go to Data.
- Data:
  - ser_valid=1, ser_out=sreg MSB, in_data=1.
  - Shift and count the same way.
  - When cnt==DATA_W-1: cnt <= 0, go to Gap.
- Gap:
  - ser_valid=0, ser_out=0.
  - cnt increments each cycle.
  - When cnt==GAP-1: done=1 for that cycle, go to Idle.
- Outputs are decoded from registered ps/sreg only, so no input-to-output combinational paths.
- Latency: first preamble bit appears on the cycle after the cycle start is sampled low in Init.
  - Frame occupies exactly PRE_W+DATA_W consecutive ser_valid cycles, then GAP cycles, then Idle.
  - Minimum start-to-ready turnaround = 1 (Idle) + Init cycles + PRE_W + DATA_W + GAP.
- start is ignored in Pre, Data and Gap; it is not queued. If start is high on the Idle cycle after done, a new Init begins.
- data_in changes outside Init have no effect on the frame in flight.
- Reset asserted mid-frame aborts immediately: ser_valid drops in the same cycle, and no done is issued.
- Unused ps encodings go to Idle with all outputs in their Idle values.

Test Plan:
- Reset: hold rst=0 with start=1 and data_in=8'hFF -> ready=1, ser_valid=0, ser_out=0, done=0. After release with start=0, stays in Idle.
- Basic frame: start high 3 cycles, data_in=8'hA5, then start=0 -> ser_out over 12 valid cycles = 1101_10100101, in_data=0 for 4 cycles then 1 for 8. Then 2 gap cycles with done on the 2nd, then ready=1.
- Late data capture: data_in=8'h00 while start=1, changed to 8'h3C on the cycle start drops -> payload bits 00111100.
- Data change mid-frame: data_in toggled every cycle during Pre/Data -> transmitted payload unchanged from the captured value.
- start during frame: assert start in Data and keep it high -> no effect until after done. Next cycle is Idle (ready=1), then Init; the second frame is sent correctly.
- Reset mid-payload: drive rst=0 on the 3rd Data bit -> ser_valid=0 and ready=1 within the same cycle, no done pulse. Next frame after release is correct.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Serial frame transmitter. A held-then-released start handshake captures a
//   parallel word. The block then shifts out a fixed preamble followed by the
//   word, MSB first, one bit per clock. It holds an idle gap and returns to
//   ready.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a request; ready=1
//   INIT  | start seen; reload shift register from data_in every cycle
//   PRE   | preamble bits on ser_out (ser_valid=1, in_data=0)
//   DATA  | payload bits on ser_out (ser_valid=1, in_data=1)
//   GAP   | idle gap after the frame; done pulses on its last cycle
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start     level request; frame starts once it is released
//   data_in   payload word, sampled while in INIT
//   ser_out   serial bit (0 when ser_valid=0)
//   ser_valid high while a frame bit is on ser_out
//   in_data   high while payload (not preamble) bits are on ser_out
//   ready     high in IDLE
//   done      one-cycle pulse on the final GAP cycle
module serial_frame_tx #(
  parameter int              PRE_W    = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = 4'b1101,
  parameter int              DATA_W   = 8,
  parameter int              GAP      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              in_data,
  output logic              ready,
  output logic              done
);

  localparam int FRAME_W = PRE_W + DATA_W;
  localparam int MAX_PD  = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAX_CNT = (MAX_PD > GAP) ? MAX_PD : GAP;
  // cnt never exceeds MAX_CNT-1
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_PRE  = 3'd2,
    S_DATA = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t             r_ps;
  state_t             w_ns;
  logic [FRAME_W-1:0] r_sreg;
  logic [FRAME_W-1:0] w_sreg_nxt;
  logic [FRAME_W-1:0] w_sreg_shl;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_sreg_shl = {r_sreg[FRAME_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ps <= S_IDLE;
    end else begin
      r_ps <= w_ns;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else begin
      r_sreg <= w_sreg_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Outputs depend only on r_ps/r_sreg, so start/data_in never reach them
  // combinationally.
  always_comb begin
    w_ns       = r_ps;
    w_sreg_nxt = r_sreg;
    w_cnt_nxt  = r_cnt;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    in_data    = 1'b0;
    ready      = 1'b0;
    done       = 1'b0;
    case (r_ps)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_ns = S_INIT;
      end
      S_INIT: begin
        // Reloaded every cycle so the word present when start drops is sent
        w_sreg_nxt = {PREAMBLE, data_in};
        w_cnt_nxt  = '0;
        if (!start) w_ns = S_PRE;
      end
      S_PRE: begin
        ser_valid  = 1'b1;
        ser_out    = r_sreg[FRAME_W-1];
        w_sreg_nxt = w_sreg_shl;
        if (r_cnt == PRE_LAST) begin
          w_cnt_nxt = '0;
          w_ns      = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        ser_valid  = 1'b1;
        in_data    = 1'b1;
        ser_out    = r_sreg[FRAME_W-1];
        w_sreg_nxt = w_sreg_shl;
        if (r_cnt == DATA_LAST) begin
          w_cnt_nxt = '0;
          w_ns      = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          done      = 1'b1;
          w_cnt_nxt = '0;
          w_ns      = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        // Unused encodings recover to IDLE and look like IDLE meanwhile
        ready = 1'b1;
        w_ns  = S_IDLE;
      end
    endcase
  end

endmodule
